// File: rtl/game_pkg.sv
// Shared types and constants for the binary math game round controller.
package game_pkg;

  localparam int NUM_W = 4;
  localparam int ANS_W = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_A,
    ST_CAP_A,
    ST_REQ_B,
    ST_CAP_B,
    ST_REQ_OP,
    ST_CAP_OP,
    ST_ASK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/answer_calc.sv
// Combinational answer generator: decides whether the operands must be swapped
// so a subtraction stays non-negative, and forms the expected 5-bit result.
module answer_calc
  import game_pkg::*;
(
  input  logic [NUM_W-1:0] a_i,
  input  logic [NUM_W-1:0] b_i,
  input  logic             op_i,
  output logic             swap_o,
  output logic [ANS_W-1:0] expected_o
);

  logic [ANS_W-1:0] a_ext;
  logic [ANS_W-1:0] b_ext;

  assign a_ext = ANS_W'(a_i);
  assign b_ext = ANS_W'(b_i);

  // Sum for add; larger minus smaller for subtract.
  always_comb begin
    swap_o = (op_i == OP_SUB) && (a_i < b_i);
    if (op_i == OP_ADD) begin
      expected_o = a_ext + b_ext;
    end else if (swap_o) begin
      expected_o = b_ext - a_ext;
    end else begin
      expected_o = a_ext - b_ext;
    end
  end

endmodule

// File: rtl/question_round_ctrl.sv
// Round controller for the binary math game. Draws operand A, operand B and
// an operator bit from the LFSR source (one Enable pulse per draw, with an
// idle-Enable cycle between draws), asks the question, judges the answer and
// keeps a saturating score over ROUNDS rounds.
// Optional feature: define ROUND_TIMER_EN to add a per-question timeout of
// TIMEOUT_CYC cycles; expiry counts as a wrong answer.
module question_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUNDS      = 10,
  parameter int SCORE_W     = 8,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Submit,
  input  logic [ANS_W-1:0]   Answer,
  input  logic [NUM_W-1:0]   Rand,
  output logic               RandEnable,
  output logic [NUM_W-1:0]   OpA,
  output logic [NUM_W-1:0]   OpB,
  output logic               OpSub,
  output logic               Asking,
  output logic               Correct,
  output logic               Wrong,
  output logic [SCORE_W-1:0] Score,
  output logic [7:0]         Round,
  output logic               GameOver
);

  localparam logic [7:0] ROUNDS_L = 8'(ROUNDS);

  state_t             state_q,   state_d;
  logic [NUM_W-1:0]   opa_q,     opa_d;
  logic [NUM_W-1:0]   opb_q,     opb_d;
  logic               opsub_q,   opsub_d;
  logic [ANS_W-1:0]   exp_q,     exp_d;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic [7:0]         round_q,   round_d;
  logic               correct_q, correct_d;
  logic               wrong_q,   wrong_d;

  logic               swap;
  logic [ANS_W-1:0]   calc_exp;
  logic [7:0]         round_inc;
  logic               expired;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  // The operator bit is judged live from Rand during CAP_OP so Expected and
  // the swapped operands land on the same edge as OpSub.
  answer_calc u_answer_calc (
    .a_i        (opa_q),
    .b_i        (opb_q),
    .op_i       (Rand[0]),
    .swap_o     (swap),
    .expected_o (calc_exp)
  );

  assign round_inc = round_q + 8'd1;

`ifdef ROUND_TIMER_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign expired = (state_q == ST_ASK) && (tmr_q == '0);

  // Load the budget on the way into ASK, count down while asking.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == ST_CAP_OP) begin
      tmr_d = TMR_W'(TIMEOUT_CYC - 1);
    end else if ((state_q == ST_ASK) && (tmr_q != '0)) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Timer register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  logic timer_unused;
  assign timer_unused = (TIMEOUT_CYC == 0);
  assign expired      = 1'b0;
`endif

  // Next-state, operand capture, judging and score/round bookkeeping.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opsub_d   = opsub_q;
    exp_d     = exp_q;
    score_d   = score_q;
    round_d   = round_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_REQ_A;
          score_d = '0;
          round_d = '0;
        end
      end
      ST_REQ_A:  state_d = ST_CAP_A;
      ST_CAP_A: begin
        opa_d   = Rand;
        state_d = ST_REQ_B;
      end
      ST_REQ_B:  state_d = ST_CAP_B;
      ST_CAP_B: begin
        opb_d   = Rand;
        state_d = ST_REQ_OP;
      end
      ST_REQ_OP: state_d = ST_CAP_OP;
      ST_CAP_OP: begin
        opsub_d = Rand[0];
        exp_d   = calc_exp;
        if (swap) begin
          opa_d = opb_q;
          opb_d = opa_q;
        end
        state_d = ST_ASK;
      end
      ST_ASK: begin
        if (Submit || expired) begin
          if (Submit && (Answer == exp_q)) begin
            correct_d = 1'b1;
            score_d   = sat_inc(score_q);
          end else begin
            wrong_d = 1'b1;
          end
          round_d = round_inc;
          state_d = (round_inc == ROUNDS_L) ? ST_DONE : ST_REQ_A;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      opsub_q   <= 1'b0;
      exp_q     <= '0;
      score_q   <= '0;
      round_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opsub_q   <= opsub_d;
      exp_q     <= exp_d;
      score_q   <= score_d;
      round_q   <= round_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
    end
  end

  assign RandEnable = (state_q == ST_REQ_A) || (state_q == ST_REQ_B) ||
                      (state_q == ST_REQ_OP);
  assign Asking     = (state_q == ST_ASK);
  assign GameOver   = (state_q == ST_DONE);
  assign OpA        = opa_q;
  assign OpB        = opb_q;
  assign OpSub      = opsub_q;
  assign Correct    = correct_q;
  assign Wrong      = wrong_q;
  assign Score      = score_q;
  assign Round      = round_q;

endmodule

// File: tb/tb_question_round_ctrl.sv
// Testbench for question_round_ctrl: a six-round game with a 2-bit score
// driven from a vector table, plus hand sequences for game end, restart,
// timeout/idle waiting and reset in the middle of a draw.
module tb_question_round_ctrl;

  localparam int ROUNDS      = 6;
  localparam int SCORE_W     = 2;
  localparam int TIMEOUT_CYC = 20;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               Start;
  logic               Submit;
  logic [4:0]         Answer;
  logic [3:0]         Rand;
  logic               RandEnable;
  logic [3:0]         OpA;
  logic [3:0]         OpB;
  logic               OpSub;
  logic               Asking;
  logic               Correct;
  logic               Wrong;
  logic [SCORE_W-1:0] Score;
  logic [7:0]         Round;
  logic               GameOver;

  int checks = 0;
  int errors = 0;

  question_round_ctrl #(
    .ROUNDS      (ROUNDS),
    .SCORE_W     (SCORE_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Submit     (Submit),
    .Answer     (Answer),
    .Rand       (Rand),
    .RandEnable (RandEnable),
    .OpA        (OpA),
    .OpB        (OpB),
    .OpSub      (OpSub),
    .Asking     (Asking),
    .Correct    (Correct),
    .Wrong      (Wrong),
    .Score      (Score),
    .Round      (Round),
    .GameOver   (GameOver)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]         a;
    logic [3:0]         b;
    logic [3:0]         op;
    logic [4:0]         ans;
    logic [3:0]         ea;
    logic [3:0]         eb;
    logic               eop;
    logic               ok;
    logic [SCORE_W-1:0] score;
    logic [7:0]         round;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge of a REQ_A cycle; returns at the negedge of the first ASK cycle.
  task automatic run_draw(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    chk("req_a_en", RandEnable, 1);
    @(negedge Clock); chk("cap_a_en", RandEnable, 0); Rand = a;
    @(negedge Clock); chk("req_b_en", RandEnable, 1); Rand = 4'h0;
    @(negedge Clock); Rand = b;
    @(negedge Clock); chk("req_op_en", RandEnable, 1); Rand = 4'h0;
    @(negedge Clock); chk("cap_op_ask", Asking, 0); Rand = op;
    @(negedge Clock); Rand = 4'h0; chk("asking", Asking, 1);
  endtask

  // Submits at the negedge of an ASK cycle; returns at the negedge after the judging edge.
  task automatic answer(input logic [4:0] ans);
    Answer = ans; Submit = 1'b1;
    @(negedge Clock); Submit = 1'b0;
  endtask

  initial begin
    vecs[0] = '{a:4'd3,  b:4'd5,  op:4'd0, ans:5'd8,  ea:4'd3,  eb:4'd5,  eop:1'b0, ok:1'b1, score:2'd1, round:8'd1};
    vecs[1] = '{a:4'd2,  b:4'd9,  op:4'd1, ans:5'd7,  ea:4'd9,  eb:4'd2,  eop:1'b1, ok:1'b1, score:2'd2, round:8'd2};
    vecs[2] = '{a:4'd2,  b:4'd9,  op:4'd1, ans:5'd11, ea:4'd9,  eb:4'd2,  eop:1'b1, ok:1'b0, score:2'd2, round:8'd3};
    vecs[3] = '{a:4'd15, b:4'd15, op:4'd0, ans:5'd30, ea:4'd15, eb:4'd15, eop:1'b0, ok:1'b1, score:2'd3, round:8'd4};
    vecs[4] = '{a:4'd4,  b:4'd1,  op:4'd1, ans:5'd3,  ea:4'd4,  eb:4'd1,  eop:1'b1, ok:1'b1, score:2'd3, round:8'd5};
    vecs[5] = '{a:4'd6,  b:4'd7,  op:4'd2, ans:5'd13, ea:4'd6,  eb:4'd7,  eop:1'b0, ok:1'b1, score:2'd3, round:8'd6};

    Reset = 1'b0; Start = 1'b0; Submit = 1'b0; Answer = '0; Rand = 4'hF;
    repeat (3) @(negedge Clock);
    chk("rst_en", RandEnable, 0);
    chk("rst_ask", Asking, 0);
    chk("rst_score", Score, 0);
    chk("rst_round", Round, 0);
    chk("rst_over", GameOver, 0);
    Reset = 1'b1; Rand = 4'h0;
    @(negedge Clock);
    chk("idle_en", RandEnable, 0);

    // Start a game: Start sampled at the end of cycle 0.
    Start = 1'b1;
    @(negedge Clock); Start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_draw(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("opa_%0d", i),   OpA,   vecs[i].ea);
      chk($sformatf("opb_%0d", i),   OpB,   vecs[i].eb);
      chk($sformatf("opsub_%0d", i), OpSub, vecs[i].eop);
      answer(vecs[i].ans);
      chk($sformatf("correct_%0d", i), Correct, vecs[i].ok);
      chk($sformatf("wrong_%0d", i),   Wrong,   !vecs[i].ok);
      chk($sformatf("score_%0d", i),   Score,   vecs[i].score);
      chk($sformatf("round_%0d", i),   Round,   vecs[i].round);
    end

    // Game over after ROUNDS; Submit in DONE is ignored.
    chk("gameover", GameOver, 1);
    chk("done_en", RandEnable, 0);
    Answer = 5'd0; Submit = 1'b1;
    @(negedge Clock); Submit = 1'b0;
    @(negedge Clock);
    chk("done_correct", Correct, 0);
    chk("done_wrong", Wrong, 0);
    chk("done_score", Score, 3);
    chk("done_round", Round, 6);
    chk("done_hold_opa", OpA, 6);

    // Restart from DONE clears score and round.
    Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    chk("restart_score", Score, 0);
    chk("restart_round", Round, 0);
    chk("restart_over", GameOver, 0);

`ifdef ROUND_TIMER_EN
    // No Submit: Wrong pulse 20 cycles after entering ASK.
    run_draw(4'd1, 4'd2, 4'd0);
    repeat (19) @(negedge Clock);
    chk("tmo_not_yet", Wrong, 0);
    chk("tmo_still_ask", Asking, 1);
    @(negedge Clock);
    chk("tmo_wrong", Wrong, 1);
    chk("tmo_round", Round, 1);
    chk("tmo_score", Score, 0);
    // Submit on the expiry cycle wins.
    run_draw(4'd1, 4'd2, 4'd0);
    repeat (19) @(negedge Clock);
    answer(5'd3);
    chk("exp_correct", Correct, 1);
    chk("exp_wrong", Wrong, 0);
    chk("exp_score", Score, 1);
    chk("exp_round", Round, 2);
`else
    // Without the timer ASK waits indefinitely.
    run_draw(4'd1, 4'd2, 4'd0);
    repeat (30) @(negedge Clock);
    chk("wait_ask", Asking, 1);
    chk("wait_wrong", Wrong, 0);
    chk("wait_round", Round, 0);
    answer(5'd3);
    chk("late_correct", Correct, 1);
    chk("late_score", Score, 1);
`endif

    // Reset asserted during REQ_B with Rand=F.
    @(negedge Clock); chk("pre_cap_a_en", RandEnable, 0); Rand = 4'd7;
    @(negedge Clock); chk("pre_req_b_en", RandEnable, 1);
    Reset = 1'b0; Rand = 4'hF;
    @(negedge Clock);
    Reset = 1'b1;
    chk("mid_rst_en", RandEnable, 0);
    chk("mid_rst_opa", OpA, 0);
    chk("mid_rst_score", Score, 0);
    chk("mid_rst_round", Round, 0);
    chk("mid_rst_correct", Correct, 0);
    chk("mid_rst_ask", Asking, 0);
    @(negedge Clock);
    chk("post_rst_idle_en", RandEnable, 0);
    chk("post_rst_over", GameOver, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
